dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Two-master arbiter and sequencer for the single-port 32-bit data RAM (word-addressed, byte strobes).
//  Master 0 = CPU data port (dmem_*); master 1 = DMA/boot-loader engine that fills RAM over the UART path.
//  Sits between the CPU/DMA and the RAM, behind the 0x0000xxxx address decode.
//  Pipelines one access per cycle, returns read data to the issuing master, and supports locked bursts for master 1.
// PARAMETERS
//  AW            14   word-address width; RAM depth = 2**AW words; ram_addr = m*_addr[AW+1:2]
//  BURST_MAX     16   max consecutive locked m1 grants before a forced release cycle (>=1)
//  STARVE_LIMIT  8    consecutive m1 denials that force an m1 grant (used only with DMEM_ARB_STARVE_GUARD_EN)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  m0_req     in   1   CPU request; addr/we/wstrb/wdata stable and held until m0_gnt
//  m0_we      in   1   1 = write, 0 = read
//  m0_wstrb   in   4   byte-write strobes, bit i -> wdata[8i+7:8i]
//  m0_addr    in   32  byte address; bits [1:0] ignored
//  m0_wdata   in   32  write data
//  m0_gnt     out  1   combinational; request accepted this cycle
//  m0_rvalid  out  1   read data valid (one-cycle pulse)
//  m0_rdata   out  32  read data
//  m1_req/m1_we/m1_wstrb/m1_addr/m1_wdata/m1_gnt/m1_rvalid/m1_rdata   same as m0_*, for the DMA master
//  m1_lock    in   1   held with m1_req: keep ownership across consecutive m1 beats
//  ram_en     out  1   RAM access strobe (registered)
//  ram_we     out  4   per-byte write enables = wstrb & {4{we}} (registered)
//  ram_addr   out  AW  word address (registered)
//  ram_wdata  out  32  write data (registered)
//  ram_rdata  in   32  synchronous RAM read data; valid the cycle after ram_en
// BEHAVIOUR
//  Reset: all outputs 0; owner=NONE; burst_cnt=0; starve_cnt=0; in-flight reads are discarded with no rvalid.
//  Pipeline: cycle N req+gnt; N+1 ram_* driven from registers; N+2 rvalid_x=1, rdata_x=ram_rdata (registered).
//   Writes commit at the end of N+1 and produce no rvalid. Throughput is 1 grant/cycle. A requester may issue back-to-back.
//  Arbitration (per cycle, at most one gnt): FSM states IDLE, OWN0, OWN1_LOCK.
//   IDLE/OWN0: m0_req wins over m1_req (fixed priority). OWN0 = last grant to m0, else IDLE.
//   m1 granted with m1_lock=1 -> OWN1_LOCK, burst_cnt=1. In OWN1_LOCK only m1 is granted; each locked grant increments burst_cnt.
//   Leave OWN1_LOCK to IDLE when m1_req=0, m1_lock=0, or burst_cnt==BURST_MAX. The exit cycle grants m0 if m0_req=1.
//   A BURST_MAX exit gives m0 priority for exactly 1 cycle. If m0 is idle, m1 may re-lock immediately.
//  Return routing: a 2-stage owner tag pipe steers ram_rdata, so a read always returns to its issuer even when ownership changes.
//  rdata_x holds its last value when rvalid_x=0. The rdata of the other master is unaffected.
//  Simultaneous m0/m1 requests to the same word in one cycle: serialized by priority, with no merging. A later read sees an earlier write (RAM order).
//  Reset mid-burst: FSM returns to IDLE asynchronously. Masters must re-request, and m1 must re-assert m1_lock.
//  Counters saturate: burst_cnt at BURST_MAX, starve_cnt at STARVE_LIMIT. Counter width is $clog2(limit+1).
// CONFIGURATION
//  DMEM_ARB_STARVE_GUARD_EN defined:
//   starve_cnt increments on each cycle with m1_req=1 and m1_gnt=0, and clears on m1_gnt.
//   When starve_cnt==STARVE_LIMIT, m1 is granted over m0 for one beat. That beat does not enter OWN1_LOCK unless m1_lock=1.
//  Undefined: no starve_cnt is instantiated. m0 has strict priority outside OWN1_LOCK, and m1 may starve indefinitely.
// TESTING
//  1. m0 read 0x0000_0010 while RAM word 4 = 0xDEADBEEF -> m0_gnt at N, ram_en/ram_addr=4 at N+1, m0_rvalid with 0xDEADBEEF at N+2.
//  2. m0 and m1 request together every cycle, lock=0 -> m0 always granted. With the guard, m1 is granted on cycle 9 (STARVE_LIMIT=8), then m0 resumes.
//  3. m1 locked burst of 20 writes, m0_req held -> 16 m1 grants, then 1 m0 grant, then 4 m1 grants. RAM words match the written data.
//  4. Byte write wstrb=4'b0100, wdata=0x00AB0000 to word 0x12345678 -> readback 0x12AB5678.
//  5. m1 read then m0 read back-to-back -> m1_rvalid at N+2 with m1's word, m0_rvalid at N+3 with m0's word. No cross delivery.
//  6. Assert rst at N+1 of an m0 read -> no m0_rvalid ever. All outputs are 0 during reset. After release the first request is granted in IDLE.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter and sequencer for the single-port 32-bit data RAM (CPU = m0, DMA = m1).
// Optional m1 starvation guard is compiled in when DMEM_ARB_STARVE_GUARD_EN is defined.
module dmem_port_arbiter #(
  parameter int AW           = 14,
  parameter int BURST_MAX    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [3:0]    m0_wstrb,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [31:0]   m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [3:0]    m1_wstrb,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [31:0]   m1_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0] BURST_MAX_C = BCW'(BURST_MAX);
  localparam logic [BCW-1:0] BURST_ONE_C = BCW'(1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_OWN0      = 2'd1,
    ST_OWN1_LOCK = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [BCW-1:0]  burst_cnt_r, burst_nxt_s;
  logic            gnt0_s, gnt1_s, lock_cont_s, starve_win_s;
  logic            sel_we_s;
  logic [3:0]      sel_wstrb_s;
  logic [AW-1:0]   sel_addr_s;
  logic [31:0]     sel_wdata_s;
  logic            ram_en_r;
  logic [3:0]      ram_we_r;
  logic [AW-1:0]   ram_addr_r;
  logic [31:0]     ram_wdata_r;
  logic            rd_v1_r, rd_own1_r;
  logic            rvalid0_r, rvalid1_r;
  logic [31:0]     hold0_r, hold1_r;
  logic            unused_s;

  // Byte-offset bits and the part of the address above the RAM window are not used.
  assign unused_s = ^{m0_addr[31:AW+2], m0_addr[1:0], m1_addr[31:AW+2], m1_addr[1:0]};

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_LIMIT_C = SCW'(STARVE_LIMIT);
  logic [SCW-1:0] starve_cnt_r;

  assign starve_win_s = (starve_cnt_r == STARVE_LIMIT_C);

  // Counts consecutive m1 denials, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= '0;
    end else if (gnt1_s) begin
      starve_cnt_r <= '0;
    end else if (m1_req && !starve_win_s) begin
      starve_cnt_r <= starve_cnt_r + SCW'(1);
    end
  end
`else
  // Guard compiled out: m1 never wins over a requesting m0 outside a lock.
  assign starve_win_s = (STARVE_LIMIT < 0);
`endif

  // Arbitration, next ownership state and burst counter.
  always_comb begin
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    state_nxt_s = ST_IDLE;
    burst_nxt_s = '0;
    case (state_r)
      ST_OWN1_LOCK: lock_cont_s = m1_req & m1_lock & (burst_cnt_r != BURST_MAX_C);
      default:      lock_cont_s = 1'b0;
    endcase
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (lock_cont_s) begin
      gnt1_s      = 1'b1;
      state_nxt_s = ST_OWN1_LOCK;
      burst_nxt_s = burst_cnt_r + BURST_ONE_C;
    end else if (m1_req && (starve_win_s || !m0_req)) begin
      gnt1_s = 1'b1;
      if (m1_lock) begin
        state_nxt_s = ST_OWN1_LOCK;
        burst_nxt_s = BURST_ONE_C;
      end else begin
        state_nxt_s = ST_IDLE;
        burst_nxt_s = '0;
      end
    end else if (m0_req) begin
      gnt0_s      = 1'b1;
      state_nxt_s = ST_OWN0;
    end else begin
      state_nxt_s = ST_IDLE;
    end
  end

  // Request fields of whichever master wins this cycle.
  always_comb begin
    if (gnt1_s) begin
      sel_we_s    = m1_we;
      sel_wstrb_s = m1_wstrb;
      sel_addr_s  = m1_addr[AW+1:2];
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_wstrb_s = m0_wstrb;
      sel_addr_s  = m0_addr[AW+1:2];
      sel_wdata_s = m0_wdata;
    end
  end

  // Ownership state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      burst_cnt_r <= burst_nxt_s;
    end
  end

  // RAM command stage plus the owner tag that follows each read to its return cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en_r    <= 1'b0;
      ram_we_r    <= 4'd0;
      ram_addr_r  <= '0;
      ram_wdata_r <= 32'd0;
      rd_v1_r     <= 1'b0;
      rd_own1_r   <= 1'b0;
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
    end else begin
      ram_en_r  <= gnt0_s | gnt1_s;
      ram_we_r  <= (gnt0_s | gnt1_s) ? (sel_wstrb_s & {4{sel_we_s}}) : 4'd0;
      rd_v1_r   <= (gnt0_s | gnt1_s) & ~sel_we_s;
      rd_own1_r <= gnt1_s;
      rvalid0_r <= rd_v1_r & ~rd_own1_r;
      rvalid1_r <= rd_v1_r & rd_own1_r;
      if (gnt0_s || gnt1_s) begin
        ram_addr_r  <= sel_addr_s;
        ram_wdata_r <= sel_wdata_s;
      end
    end
  end

  // Last delivered word per master, shown while that master has no rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0_r <= 32'd0;
      hold1_r <= 32'd0;
    end else begin
      if (rvalid0_r) hold0_r <= ram_rdata;
      if (rvalid1_r) hold1_r <= ram_rdata;
    end
  end

  assign m0_gnt    = gnt0_s;
  assign m1_gnt    = gnt1_s;
  assign m0_rvalid = rvalid0_r;
  assign m1_rvalid = rvalid1_r;
  assign m0_rdata  = rvalid0_r ? ram_rdata : hold0_r;
  assign m1_rdata  = rvalid1_r ? ram_rdata : hold1_r;
  assign ram_en    = ram_en_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: RAM model, reference model with per-cycle compare,
// and directed scenarios with literal expectations. Honors DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_port_arbiter;
  localparam int AW           = 14;
  localparam int BURST_MAX    = 16;
  localparam int STARVE_LIMIT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [3:0]    m0_wstrb;
  logic [31:0]   m0_addr, m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [3:0]    m1_wstrb;
  logic [31:0]   m1_addr, m1_wdata, m1_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'd0;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .BURST_MAX(BURST_MAX), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM with byte enables (read-before-write).
  logic [31:0] ram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= ram_mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference model: memory image in grant order, one-cycle command stage, one-cycle return stage.
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  logic          s1_v, s1_rd, s1_own, s2_v, s2_own;
  logic [3:0]    s1_we;
  logic [AW-1:0] s1_addr;
  logic [31:0]   s1_wdata, s1_data, s2_data, hold0, hold1;
  int            m1_run, starve;

  always @(negedge clk) begin : compare
    logic e0, e1, cont, force1, ev0, ev1, we_g;
    logic [AW-1:0] a;
    logic [31:0] wd;
    logic [3:0] st;
    if (rst) begin
      chk1("rst_m0_gnt", m0_gnt, 1'b0);
      chk1("rst_m1_gnt", m1_gnt, 1'b0);
      chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
      chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
      chk1("rst_ram_en", ram_en, 1'b0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_ram_wdata", ram_wdata, 32'd0);
      s1_v = 1'b0; s2_v = 1'b0; hold0 = 32'd0; hold1 = 32'd0; m1_run = 0; starve = 0;
    end else begin
      chk1("ram_en", ram_en, s1_v);
      if (s1_v) begin
        check("ram_we", 32'(ram_we), 32'(s1_we));
        check("ram_addr", 32'(ram_addr), 32'(s1_addr));
        check("ram_wdata", ram_wdata, s1_wdata);
      end
      ev0 = s2_v & ~s2_own;
      ev1 = s2_v & s2_own;
      if (ev0) hold0 = s2_data;
      if (ev1) hold1 = s2_data;
      chk1("m0_rvalid", m0_rvalid, ev0);
      chk1("m1_rvalid", m1_rvalid, ev1);
      check("m0_rdata", m0_rdata, hold0);
      check("m1_rdata", m1_rdata, hold1);
      // A lock run continues while below BURST_MAX beats; otherwise m0 first unless m1 is starved.
      cont = (m1_run > 0) && (m1_run < BURST_MAX) && m1_req && m1_lock;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      force1 = (starve == STARVE_LIMIT) && m1_req;
`else
      force1 = 1'b0;
`endif
      e1 = cont || force1 || (m1_req && !m0_req);
      e0 = !e1 && m0_req;
      chk1("m0_gnt", m0_gnt, e0);
      chk1("m1_gnt", m1_gnt, e1);
      s2_v = s1_v & s1_rd; s2_own = s1_own; s2_data = s1_data;
      we_g = e1 ? m1_we : m0_we;
      st   = e1 ? m1_wstrb : m0_wstrb;
      a    = e1 ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
      wd   = e1 ? m1_wdata : m0_wdata;
      s1_v = e0 | e1; s1_rd = ~we_g; s1_own = e1;
      s1_we = st & {4{we_g}}; s1_addr = a; s1_wdata = wd;
      if (s1_v) begin
        s1_data = ref_mem[a];
        if (we_g)
          for (int b = 0; b < 4; b++)
            if (st[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
      end
      m1_run = (e1 && m1_lock) ? (cont ? m1_run + 1 : 1) : 0;
      if (e1) starve = 0;
      else if (m1_req && starve < STARVE_LIMIT) starve++;
    end
  end

  // Snapshot of DUT outputs taken mid-cycle by the stimulus.
  logic g0, g1, sv0, sv1, s_en;
  logic [31:0] sd0, sd1, s_addr;

  task automatic step();
    @(negedge clk);
    g0 = m0_gnt; g1 = m1_gnt; sv0 = m0_rvalid; sv1 = m1_rvalid;
    sd0 = m0_rdata; sd1 = m1_rdata; s_en = ram_en; s_addr = 32'(ram_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    ram_mem[w] = d;
    ref_mem[w] = d;
  endtask

  initial begin : stim
    int seq[$];
    int i, n0, n1, first1;
    bit m0_pend, m0_done;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_wstrb = 4'd0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_wstrb = 4'd0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_lock = 1'b0;
    for (int k = 0; k < (1 << AW); k++) preload(k, 32'd0);
    preload(4, 32'hDEAD_BEEF);
    preload(32'h20, 32'h1234_5678);
    preload(32'h30, 32'h1111_1111);
    preload(32'h31, 32'h2222_2222);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: m0 read of word 4
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
    step(); chk1("t1_gnt", g0, 1'b1);
    m0_req = 1'b0;
    step(); chk1("t1_ram_en", s_en, 1'b1); check("t1_ram_addr", s_addr, 32'd4);
    step(); chk1("t1_rvalid", sv0, 1'b1); check("t1_rdata", sd0, 32'hDEAD_BEEF);

    // 4: byte-lane write then readback
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h80; m0_wstrb = 4'b0100; m0_wdata = 32'h00AB_0000;
    step(); chk1("t4_wgnt", g0, 1'b1);
    m0_we = 1'b0; m0_wstrb = 4'd0;
    step(); chk1("t4_rgnt", g0, 1'b1);
    m0_req = 1'b0;
    step(); step(); chk1("t4_rvalid", sv0, 1'b1); check("t4_rdata", sd0, 32'h12AB_5678);

    // 5: m1 read then m0 read, no cross delivery
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'hC0;
    step(); chk1("t5_g1", g1, 1'b1);
    m1_req = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hC4;
    step(); chk1("t5_g0", g0, 1'b1);
    m0_req = 1'b0;
    step(); chk1("t5_m1_rvalid", sv1, 1'b1); check("t5_m1_rdata", sd1, 32'h1111_1111);
    chk1("t5_m0_quiet", sv0, 1'b0);
    step(); chk1("t5_m0_rvalid", sv0, 1'b1); check("t5_m0_rdata", sd0, 32'h2222_2222);
    chk1("t5_m1_quiet", sv1, 1'b0); check("t5_m1_hold", sd1, 32'h1111_1111);

    // 3: 20-beat locked m1 burst with m0 waiting from beat 2
    i = 0; m0_pend = 1'b0; m0_done = 1'b0;
    for (int c = 0; c < 60 && (i < 20 || m0_pend); c++) begin
      m1_req = (i < 20); m1_lock = 1'b1; m1_we = 1'b1; m1_wstrb = 4'hF;
      m1_addr = 32'((32'h100 + i) << 2); m1_wdata = 32'(32'hA500_0000 + i);
      m0_req = m0_pend; m0_we = 1'b0; m0_addr = 32'h10;
      step();
      if (g1) begin seq.push_back(1); i++; if (!m0_done) m0_pend = 1'b1; end
      if (g0) begin seq.push_back(0); m0_pend = 1'b0; m0_done = 1'b1; end
    end
    m1_req = 1'b0; m1_lock = 1'b0; m0_req = 1'b0;
    check("t3_grants", 32'(seq.size()), 32'd21);
    for (int k = 0; k < seq.size() && k < 21; k++)
      check($sformatf("t3_seq%0d", k), 32'(seq[k]), (k == 16) ? 32'd0 : 32'd1);
    step(); step(); step();
    for (int k = 0; k < 20; k++)
      check($sformatf("t3_mem%0d", k), ram_mem[32'h100 + k], 32'(32'hA500_0000 + k));

    // 2: both masters request every cycle, no lock
    n0 = 0; n1 = 0; first1 = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h14; m1_lock = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (g0) n0++;
      if (g1) begin n1++; if (first1 == 0) first1 = c; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    check("t2_m1_grants", 32'(n1), 32'd1);
    check("t2_m1_cycle", 32'(first1), 32'd9);
    check("t2_m0_grants", 32'(n0), 32'd11);
`else
    check("t2_m1_grants", 32'(n1), 32'd0);
    check("t2_m0_grants", 32'(n0), 32'd12);
`endif
    step(); step(); step();

    // 6: reset during the RAM cycle of an m0 read
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    step(); chk1("t6_gnt", g0, 1'b1);
    rst = 1'b1; m0_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk1("t6_no_rvalid", sv0, 1'b0);
    end
    rst = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'h14;
    step(); chk1("t6_first_gnt", g1, 1'b1);
    m1_req = 1'b0;
    step(); chk1("t6_post_rvalid0", sv0, 1'b0);
    step(); chk1("t6_post_rvalid0b", sv0, 1'b0); chk1("t6_m1_rvalid", sv1, 1'b1);
    check("t6_m1_rdata", sd1, 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
